// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: write FIFO plus single-read arbiter driving the SDRAM controller's level-held handshake.
// Define SDRAM_ARB_TIMEOUT_EN to add the completion timeout and sticky timeout_err.
module sdram_req_arbiter #(
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_WR_BURST = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                        clk_100MHz,
  input  logic                        rst,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [23:0]                 wr_addr,
  input  logic [15:0]                 wr_wdata,
  input  logic                        rdq_valid,
  output logic                        rdq_ready,
  input  logic [23:0]                 rdq_addr,
  output logic                        rdr_valid,
  output logic [15:0]                 rdr_data,
  output logic [23:0]                 addr,
  output logic                        wr_req,
  output logic [15:0]                 wr_data,
  output logic                        rd_req,
  input  logic [15:0]                 rd_data,
  input  logic                        rd_ready,
  input  logic                        wr_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(MAX_WR_BURST + 1);
  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, GAP} state_t;
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 32 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      MAX_WR_BURST < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("sdram_req_arbiter: unsupported parameter value");
  end
  state_t state_q, state_d;
  logic [39:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] lvl_q, lvl_d;
  logic wrdy_q;
  logic [SW-1:0] streak_q, streak_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic rvld_q, rvld_d;
  logic push, pop, empty, tmo_exp;
  assign push  = wr_valid && wrdy_q;
  assign pop   = state_q == WR_REQ && (wr_done || tmo_exp);
  assign empty = lvl_q == '0;
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    rvld_d    = 1'b0;
    rdq_ready = 1'b0;
    wp_d      = wp_q + AW'(push);
    rp_d      = rp_q + AW'(pop);
    lvl_d     = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
    case (state_q)
      IDLE:
        if (!rst && rdq_valid && (empty || streak_q >= SW'(MAX_WR_BURST))) begin
          rdq_ready = 1'b1;
          addr_d    = rdq_addr;
          streak_d  = '0;
          state_d   = RD_REQ;
        end else if (!empty) begin
          {addr_d, wdat_d} = mem_q[rp_q];
          streak_d = streak_q + SW'(streak_q < SW'(MAX_WR_BURST));
          state_d  = WR_REQ;
        end
      WR_REQ: state_d = wr_done || tmo_exp ? GAP : WR_REQ;
      RD_REQ:
        if (rd_ready || tmo_exp) begin
          rvld_d  = 1'b1;
          rdat_d  = rd_ready ? rd_data : 16'h0000;
          state_d = GAP;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_100MHz)
    if (push) mem_q[wp_q] <= {wr_addr, wr_wdata};
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q  <= IDLE;
      wp_q     <= '0;
      rp_q     <= '0;
      lvl_q    <= '0;
      wrdy_q   <= 1'b0;
      streak_q <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      rvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      lvl_q    <= lvl_d;
      wrdy_q   <= lvl_d != (AW+1)'(FIFO_DEPTH);
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      rvld_q   <= rvld_d;
    end
  end
`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic err_q, err_d, busy;
  always_comb begin
    busy    = state_q == WR_REQ || state_q == RD_REQ;
    tmo_exp = busy && tmo_q == TW'(TIMEOUT - 1);
    tmo_d   = busy && !tmo_exp ? tmo_q + TW'(1) : '0;
    err_d   = err_q || tmo_exp;
  end
  always_ff @(posedge clk_100MHz) begin
    tmo_q <= rst ? '0 : tmo_d;
    err_q <= rst ? 1'b0 : err_d;
  end
  assign timeout_err = err_q;
`else
  assign tmo_exp     = 1'b0;
  assign timeout_err = 1'b0;
`endif
  assign wr_ready   = wrdy_q;
  assign wr_req     = state_q == WR_REQ;
  assign rd_req     = state_q == RD_REQ;
  assign addr       = addr_q;
  assign wr_data    = wdat_q;
  assign rdr_valid  = rvld_q;
  assign rdr_data   = rdat_q;
  assign fifo_level = lvl_q;
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb_sdram_req_arbiter: directed vector table for single write/read handshakes, plus
// hand sequences for FIFO full/blocking, read fairness, reset mid-read and request hold/timeout.
module tb_sdram_req_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic wr_valid = 1'b0, rdq_valid = 1'b0, rd_ready = 1'b0, wr_done = 1'b0;
  logic [23:0] wr_addr = '0, rdq_addr = '0;
  logic [15:0] wr_wdata = '0, rd_data = '0;
  logic wr_ready, rdq_ready, rdr_valid, wr_req, rd_req, timeout_err;
  logic [15:0] rdr_data, wr_data;
  logic [23:0] addr;
  logic [3:0] fifo_level;
  int n_cmp = 0, n_bad = 0;

  sdram_req_arbiter dut (
    .clk_100MHz(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_wdata(wr_wdata), .rdq_valid(rdq_valid), .rdq_ready(rdq_ready), .rdq_addr(rdq_addr),
    .rdr_valid(rdr_valid), .rdr_data(rdr_data), .addr(addr), .wr_req(wr_req), .wr_data(wr_data),
    .rd_req(rd_req), .rd_data(rd_data), .rd_ready(rd_ready), .wr_done(wr_done),
    .fifo_level(fifo_level), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic wv; logic [23:0] wa; logic [15:0] wd; logic rv; logic [23:0] ra;
    logic rr; logic [15:0] rdd; logic wdn;
  } in_t;
  typedef struct packed {
    logic wrdy; logic rqr; logic wreq; logic rreq; logic [23:0] addr;
    logic [15:0] wdat; logic rv; logic [15:0] rdat; logic [3:0] lvl;
  } exp_t;
  typedef struct packed { in_t i; exp_t e; } vec_t;
  vec_t v [20];

  function automatic in_t mi(logic wv, logic [23:0] wa, logic [15:0] wd, logic rv,
                             logic [23:0] ra, logic rr, logic [15:0] rdd, logic wdn);
    return {wv, wa, wd, rv, ra, rr, rdd, wdn};
  endfunction
  function automatic exp_t me(logic wrdy, logic rqr, logic wreq, logic rreq, logic [23:0] a,
                              logic [15:0] wdat, logic rv, logic [15:0] rdat, logic [3:0] lvl);
    return {wrdy, rqr, wreq, rreq, a, wdat, rv, rdat, lvl};
  endfunction
  function automatic logic [23:0] fa(int i);
    return 24'h10_0000 + 24'(i);
  endfunction
  function automatic logic [15:0] fd(int i);
    return 16'hC000 + 16'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {wr_valid, rdq_valid, rd_ready, wr_done} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [23:0] A1 = 24'h40_1234, A2 = 24'h00_0010, A3 = 24'h12_3456, A4 = 24'h00_0020;
  localparam logic [15:0] D1 = 16'hBEEF, R1 = 16'hA5A5, D3 = 16'h1111, R2 = 16'h5A5A;
  localparam in_t I0 = '0;

  logic [23:0] seq [9];
  int stamp [9];
  int ng, nrv, hi, t;
  bit gr;

  initial begin
    v[0]  = {I0,                                  me(0,0,0,0,'0,'0,0,'0,0)};
    v[1]  = {mi(1,A1,D1,0,'0,0,'0,0),             me(1,0,0,0,'0,'0,0,'0,0)};
    v[2]  = {I0,                                  me(1,0,0,0,'0,'0,0,'0,1)};
    v[3]  = {I0,                                  me(1,0,1,0,A1,D1,0,'0,1)};
    v[4]  = {I0,                                  me(1,0,1,0,A1,D1,0,'0,1)};
    v[5]  = {I0,                                  me(1,0,1,0,A1,D1,0,'0,1)};
    v[6]  = {mi(0,'0,'0,0,'0,0,'0,1),             me(1,0,1,0,A1,D1,0,'0,1)};
    v[7]  = {I0,                                  me(1,0,0,0,A1,D1,0,'0,0)};
    v[8]  = {mi(0,'0,'0,1,A2,0,'0,0),             me(1,1,0,0,A1,D1,0,'0,0)};
    v[9]  = {mi(0,'0,'0,0,'0,0,'0,1),             me(1,0,0,1,A2,D1,0,'0,0)};
    v[10] = {mi(0,'0,'0,0,'0,1,R1,0),             me(1,0,0,1,A2,D1,0,'0,0)};
    v[11] = {mi(0,'0,'0,0,'0,1,16'hFFFF,0),       me(1,0,0,0,A2,D1,1,R1,0)};
    v[12] = {mi(1,A3,D3,0,'0,0,'0,0),             me(1,0,0,0,A2,D1,0,R1,0)};
    v[13] = {mi(0,'0,'0,1,A4,0,'0,0),             me(1,0,0,0,A2,D1,0,R1,1)};
    v[14] = {mi(0,'0,'0,1,A4,0,'0,1),             me(1,0,1,0,A3,D3,0,R1,1)};
    v[15] = {mi(0,'0,'0,1,A4,0,'0,0),             me(1,0,0,0,A3,D3,0,R1,0)};
    v[16] = {mi(0,'0,'0,1,A4,0,'0,0),             me(1,1,0,0,A3,D3,0,R1,0)};
    v[17] = {mi(0,'0,'0,0,'0,1,R2,0),             me(1,0,0,1,A4,D3,0,R1,0)};
    v[18] = {I0,                                  me(1,0,0,0,A4,D3,1,R2,0)};
    v[19] = {I0,                                  me(1,0,0,0,A4,D3,0,R2,0)};

    do_reset();
    for (int k = 0; k < 20; k++) begin
      {wr_valid, wr_addr, wr_wdata, rdq_valid, rdq_addr, rd_ready, rd_data, wr_done} = v[k].i;
      #1;
      chk($sformatf("v%0d wr_ready", k), 32'(wr_ready), 32'(v[k].e.wrdy));
      chk($sformatf("v%0d rdq_ready", k), 32'(rdq_ready), 32'(v[k].e.rqr));
      chk($sformatf("v%0d wr_req", k), 32'(wr_req), 32'(v[k].e.wreq));
      chk($sformatf("v%0d rd_req", k), 32'(rd_req), 32'(v[k].e.rreq));
      chk($sformatf("v%0d addr", k), 32'(addr), 32'(v[k].e.addr));
      chk($sformatf("v%0d wr_data", k), 32'(wr_data), 32'(v[k].e.wdat));
      chk($sformatf("v%0d rdr_valid", k), 32'(rdr_valid), 32'(v[k].e.rv));
      chk($sformatf("v%0d rdr_data", k), 32'(rdr_data), 32'(v[k].e.rdat));
      chk($sformatf("v%0d fifo_level", k), 32'(fifo_level), 32'(v[k].e.lvl));
      chk($sformatf("v%0d timeout_err", k), 32'(timeout_err), 32'h0);
      @(negedge clk);
    end

    // fill to full, block the 9th push, free one slot, then drain in order
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = fa(i); wr_wdata = fd(i);
      @(negedge clk);
    end
    wr_addr = fa(8); wr_wdata = fd(8);
    #1;
    chk("full level", 32'(fifo_level), 32'd8);
    chk("full wr_ready", 32'(wr_ready), 32'd0);
    chk("full head addr", 32'(addr), 32'(fa(0)));
    repeat (3) @(negedge clk);
    chk("blocked level", 32'(fifo_level), 32'd8);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    #1;
    chk("freed wr_ready", 32'(wr_ready), 32'd1);
    chk("freed level", 32'(fifo_level), 32'd7);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("refill level", 32'(fifo_level), 32'd8);
    chk("refill wr_ready", 32'(wr_ready), 32'd0);
    for (int j = 1; j < 9; j++) begin
      t = 0;
      while (!wr_req && t < 10) begin @(negedge clk); t++; end
      chk($sformatf("drain%0d wr_req", j), 32'(wr_req), 32'd1);
      chk($sformatf("drain%0d addr", j), 32'(addr), 32'(fa(j)));
      chk($sformatf("drain%0d data", j), 32'(wr_data), 32'(fd(j)));
      wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
    end
    #1;
    chk("drained level", 32'(fifo_level), 32'd0);

    // fairness: full FIFO plus pending read -> 4 writes, read, rest of writes
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = fa(i + 16); wr_wdata = fd(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rdq_valid = 1'b1; rdq_addr = 24'h00_0030;
    ng = 0; nrv = 0; gr = 1'b0;
    for (int c = 0; c < 100 && ng < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (gr) rdq_valid = 1'b0;
      #1;
      gr = rdq_valid && rdq_ready;
      chk("fair overlap", 32'(wr_req && rd_req), 32'd0);
      if (rdr_valid) begin
        nrv++;
        chk("fair rdr_data", 32'(rdr_data), 32'h7E57);
      end
      wr_done = wr_req; rd_ready = rd_req; rd_data = 16'h7E57;
      if (wr_req || rd_req) begin seq[ng] = addr; stamp[ng] = c; ng++; end
    end
    @(negedge clk);
    {wr_done, rd_ready, rdq_valid} = '0;
    chk("fair grants", 32'(ng), 32'd9);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("fair order%0d", k), 32'(seq[k]),
          32'(k == 4 ? 24'h00_0030 : fa((k < 4 ? k : k - 1) + 16)));
      if (k > 0) chk($sformatf("fair spacing%0d", k), 32'(stamp[k] - stamp[k-1]), 32'd3);
    end
    chk("fair rdr pulses", 32'(nrv), 32'd1);

    // reset while a read is outstanding and a write is queued
    do_reset();
    @(negedge clk);
    rdq_valid = 1'b1; rdq_addr = 24'h00_0040;
    #1;
    chk("rst rdq_ready", 32'(rdq_ready), 32'd1);
    @(negedge clk);
    rdq_valid = 1'b0;
    wr_valid = 1'b1; wr_addr = 24'h05_0505; wr_wdata = 16'h0505;
    #1;
    chk("rst rd_req", 32'(rd_req), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("rst pre level", 32'(fifo_level), 32'd1);
    rst = 1'b1; rd_ready = 1'b1; rd_data = 16'h1234;
    @(negedge clk);
    rst = 1'b0; rd_ready = 1'b0;
    #1;
    chk("rst rd_req0", 32'(rd_req), 32'd0);
    chk("rst wr_req0", 32'(wr_req), 32'd0);
    chk("rst level0", 32'(fifo_level), 32'd0);
    chk("rst wr_ready0", 32'(wr_ready), 32'd0);
    chk("rst addr0", 32'(addr), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("post-rst rdr_valid", 32'(rdr_valid), 32'd0);
      chk("post-rst reqs", 32'({wr_req, rd_req}), 32'd0);
    end
    chk("post-rst wr_ready", 32'(wr_ready), 32'd1);

    // write never acknowledged: held indefinitely, or dropped after TIMEOUT cycles
    do_reset();
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 24'h33_0000; wr_wdata = 16'hD00D;
    @(negedge clk);
    wr_valid = 1'b0;
    hi = 0; nrv = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      #1;
      if (wr_req) hi++;
      if (rdr_valid) nrv++;
    end
    chk("hold rdr_valid", 32'(nrv), 32'd0);
`ifdef SDRAM_ARB_TIMEOUT_EN
    chk("tmo wr_req cycles", 32'(hi), 32'd64);
    chk("tmo err", 32'(timeout_err), 32'd1);
    chk("tmo discarded", 32'(fifo_level), 32'd0);
    chk("tmo wr_req low", 32'(wr_req), 32'd0);
`else
    chk("hold wr_req cycles", 32'(hi), 32'd150);
    chk("hold err", 32'(timeout_err), 32'd0);
    chk("hold level", 32'(fifo_level), 32'd1);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    #1;
    chk("hold release wr_req", 32'(wr_req), 32'd0);
    chk("hold release level", 32'(fifo_level), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
